// File: rtl/alu.sv
// -----------------------------------------------------------------------------
// alu -- registered integer ALU for the datapath execute stage.
//
// Each cycle one operation is computed on op1/op2, selected by alu_sel. The
// result and its zero/carry/overflow flags are registered, so outputs show
// the operation whose inputs were sampled on the previous rising edge.
//
// Ports:
//   clk       in   1      system clock, rising-edge active
//   rst_n     in   1      synchronous active-low reset
//   op1       in   WIDTH  operand A
//   op2       in   WIDTH  operand B (shifts use only op2[SHAMT_W-1:0])
//   alu_sel   in   4      operation select
//   alu_out   out  WIDTH  registered result
//   zero      out  1      registered, result == 0
//   carry     out  1      registered, ADD carry-out / SUB borrow
//   overflow  out  1      registered, signed overflow for ADD/SUB
// -----------------------------------------------------------------------------
module alu #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic [3:0]       alu_sel,
  output logic [WIDTH-1:0] alu_out,
  output logic             zero,
  output logic             carry,
  output logic             overflow
);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0100;
  localparam logic [3:0] OP_OR   = 4'b0101;
  localparam logic [3:0] OP_XOR  = 4'b0110;
  localparam logic [3:0] OP_NOR  = 4'b0111;
  localparam logic [3:0] OP_SLL  = 4'b1000;
  localparam logic [3:0] OP_SRL  = 4'b1001;
  localparam logic [3:0] OP_SRA  = 4'b1010;
  localparam logic [3:0] OP_SLT  = 4'b1011;
  localparam logic [3:0] OP_SLTU = 4'b1100;
  localparam logic [3:0] OP_EQ   = 4'b1101;
  localparam logic [3:0] OP_NE   = 4'b1110;

  // One extra bit on the adder/subtractor exposes carry-out and borrow.
  logic [WIDTH:0]          sum_ext_s;
  logic [WIDTH:0]          diff_ext_s;
  logic [SHAMT_W-1:0]      shamt_s;
  logic signed [WIDTH-1:0] op1_sgn_s;
  logic signed [WIDTH-1:0] op2_sgn_s;

  logic [WIDTH-1:0] alu_out_d, alu_out_q;
  logic             zero_d,    zero_q;
  logic             carry_d,   carry_q;
  logic             overflow_d, overflow_q;

  assign sum_ext_s  = {1'b0, op1} + {1'b0, op2};
  assign diff_ext_s = {1'b0, op1} - {1'b0, op2};
  assign shamt_s    = op2[SHAMT_W-1:0];
  assign op1_sgn_s  = op1;
  assign op2_sgn_s  = op2;

  // Combinational datapath: result and flags for the current inputs.
  always_comb begin
    alu_out_d  = {WIDTH{1'b0}};
    carry_d    = 1'b0;
    overflow_d = 1'b0;
    case (alu_sel)
      OP_ADD: begin
        alu_out_d  = sum_ext_s[WIDTH-1:0];
        carry_d    = sum_ext_s[WIDTH];
        overflow_d = (op1[WIDTH-1] == op2[WIDTH-1]) &&
                     (sum_ext_s[WIDTH-1] != op1[WIDTH-1]);
      end
      OP_SUB: begin
        alu_out_d  = diff_ext_s[WIDTH-1:0];
        // Top bit of the widened difference is set exactly when op1 < op2.
        carry_d    = diff_ext_s[WIDTH];
        overflow_d = (op1[WIDTH-1] != op2[WIDTH-1]) &&
                     (diff_ext_s[WIDTH-1] != op1[WIDTH-1]);
      end
      OP_AND:  alu_out_d = op1 & op2;
      OP_OR:   alu_out_d = op1 | op2;
      OP_XOR:  alu_out_d = op1 ^ op2;
      OP_NOR:  alu_out_d = ~(op1 | op2);
      OP_SLL:  alu_out_d = op1 << shamt_s;
      OP_SRL:  alu_out_d = op1 >> shamt_s;
      OP_SRA:  alu_out_d = op1_sgn_s >>> shamt_s;
      OP_SLT:  alu_out_d = {{(WIDTH-1){1'b0}}, (op1_sgn_s < op2_sgn_s)};
      OP_SLTU: alu_out_d = {{(WIDTH-1){1'b0}}, (op1 < op2)};
      OP_EQ:   alu_out_d = {{(WIDTH-1){1'b0}}, (op1 == op2)};
      OP_NE:   alu_out_d = {{(WIDTH-1){1'b0}}, (op1 != op2)};
      // Reserved and undecodable selects produce a zero result.
      default: alu_out_d = {WIDTH{1'b0}};
    endcase
    zero_d = (alu_out_d == {WIDTH{1'b0}});
  end

  // Output register bank; reset wins over any operation in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alu_out_q  <= {WIDTH{1'b0}};
      zero_q     <= 1'b0;
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      alu_out_q  <= alu_out_d;
      zero_q     <= zero_d;
      carry_q    <= carry_d;
      overflow_q <= overflow_d;
    end
  end

  assign alu_out  = alu_out_q;
  assign zero     = zero_q;
  assign carry    = carry_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_alu.sv
// -----------------------------------------------------------------------------
// tb_alu -- directed self-checking bench for the registered ALU.
// Each step drives inputs, waits one rising edge, then checks outputs 1ns
// later against hand-computed values.
// -----------------------------------------------------------------------------
module tb_alu;

  logic        clk;
  logic        rst_n;
  logic [31:0] op1;
  logic [31:0] op2;
  logic [3:0]  alu_sel;
  logic [31:0] alu_out;
  logic        zero;
  logic        carry;
  logic        overflow;

  int vectors;
  int miscompares;

  localparam logic [3:0] ADD  = 4'b0000;
  localparam logic [3:0] SUB  = 4'b0001;
  localparam logic [3:0] AND_ = 4'b0100;
  localparam logic [3:0] OR_  = 4'b0101;
  localparam logic [3:0] XOR_ = 4'b0110;
  localparam logic [3:0] NOR_ = 4'b0111;
  localparam logic [3:0] SLL  = 4'b1000;
  localparam logic [3:0] SRL  = 4'b1001;
  localparam logic [3:0] SRA  = 4'b1010;
  localparam logic [3:0] SLT  = 4'b1011;
  localparam logic [3:0] SLTU = 4'b1100;
  localparam logic [3:0] EQ   = 4'b1101;
  localparam logic [3:0] NE   = 4'b1110;

  alu #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .op1      (op1),
    .op2      (op2),
    .alu_sel  (alu_sel),
    .alu_out  (alu_out),
    .zero     (zero),
    .carry    (carry),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input string tag, input logic rst_v,
                      input logic [3:0] sel, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] exp_out,
                      input logic exp_z, input logic exp_c, input logic exp_v);
    rst_n   = rst_v;
    alu_sel = sel;
    op1     = a;
    op2     = b;
    @(posedge clk);
    #1;
    vectors++;
    assert ({alu_out, zero, carry, overflow} === {exp_out, exp_z, exp_c, exp_v})
    else begin
      miscompares++;
      $error("FAIL %s: got out=%08h z=%b c=%b v=%b, expected out=%08h z=%b c=%b v=%b",
             tag, alu_out, zero, carry, overflow, exp_out, exp_z, exp_c, exp_v);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;

    // Reset held for two edges, then released.
    step("rst_edge1",   1'b0, ADD, 32'h10, 32'h20, 32'h0, 1'b0, 1'b0, 1'b0);
    step("rst_edge2",   1'b0, ADD, 32'h10, 32'h20, 32'h0, 1'b0, 1'b0, 1'b0);
    step("rst_release", 1'b1, ADD, 32'h10, 32'h20, 32'h30, 1'b0, 1'b0, 1'b0);

    // Arithmetic
    step("add_ovf",    1'b1, ADD, 32'h7FFFFFFF, 32'h1, 32'h80000000, 1'b0, 1'b0, 1'b1);
    step("add_wrap",   1'b1, ADD, 32'hFFFFFFFF, 32'h1, 32'h0,        1'b1, 1'b1, 1'b0);
    step("add_carry",  1'b1, ADD, 32'hFFFFFFFF, 32'h2, 32'h1,        1'b0, 1'b1, 1'b0);
    step("sub_pos",    1'b1, SUB, 32'h20, 32'h10,       32'h10,       1'b0, 1'b0, 1'b0);
    step("sub_borrow", 1'b1, SUB, 32'h10, 32'h20,       32'hFFFFFFF0, 1'b0, 1'b1, 1'b0);
    step("sub_ovf",    1'b1, SUB, 32'h80000000, 32'h1,  32'h7FFFFFFF, 1'b0, 1'b0, 1'b1);

    // Logic (AND follows an overflow to confirm flags clear)
    step("and",  1'b1, AND_, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'h0,        1'b1, 1'b0, 1'b0);
    step("or",   1'b1, OR_,  32'hF0F0F0F0, 32'h0F0F0F0F, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
    step("xor",  1'b1, XOR_, 32'hAAAAAAAA, 32'h55555555, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
    step("nor",  1'b1, NOR_, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'h0,        1'b1, 1'b0, 1'b0);
    step("nor2", 1'b1, NOR_, 32'h0000FF00, 32'h00000F0F, 32'hFFFF00F0, 1'b0, 1'b0, 1'b0);

    // Shifts
    step("sll",       1'b1, SLL, 32'h1,        32'h2,  32'h4,        1'b0, 1'b0, 1'b0);
    step("srl",       1'b1, SRL, 32'h4,        32'h1,  32'h2,        1'b0, 1'b0, 1'b0);
    step("sra_neg",   1'b1, SRA, 32'h80000000, 32'h1,  32'hC0000000, 1'b0, 1'b0, 1'b0);
    step("sra_pos",   1'b1, SRA, 32'h40000000, 32'h4,  32'h04000000, 1'b0, 1'b0, 1'b0);
    step("srl_31",    1'b1, SRL, 32'h80000000, 32'h1F, 32'h1,        1'b0, 1'b0, 1'b0);
    step("sll_hibit", 1'b1, SLL, 32'h1,        32'h21, 32'h2,        1'b0, 1'b0, 1'b0);
    step("sll_zero",  1'b1, SLL, 32'h1234,     32'h20, 32'h1234,     1'b0, 1'b0, 1'b0);

    // Compares
    step("sltu_lt",  1'b1, SLTU, 32'h10,       32'h20,       32'h1, 1'b0, 1'b0, 1'b0);
    step("sltu_big", 1'b1, SLTU, 32'hFFFFFFFF, 32'h1,        32'h0, 1'b1, 1'b0, 1'b0);
    step("slt_neg",  1'b1, SLT,  32'hFFFFFFFF, 32'h1,        32'h1, 1'b0, 1'b0, 1'b0);
    step("slt_pos",  1'b1, SLT,  32'h1,        32'hFFFFFFFF, 32'h0, 1'b1, 1'b0, 1'b0);
    step("eq",       1'b1, EQ,   32'h20,       32'h20,       32'h1, 1'b0, 1'b0, 1'b0);
    step("eq_ne",    1'b1, EQ,   32'h20,       32'h21,       32'h0, 1'b1, 1'b0, 1'b0);
    step("ne_same",  1'b1, NE,   32'h20,       32'h20,       32'h0, 1'b1, 1'b0, 1'b0);
    step("ne_diff",  1'b1, NE,   32'h20,       32'h21,       32'h1, 1'b0, 1'b0, 1'b0);

    // Reserved codes, back-to-back with an ADD, then reset mid-stream
    step("rsv_0010",   1'b1, 4'b0010, 32'h5, 32'h6,        32'h0,   1'b1, 1'b0, 1'b0);
    step("pipe_add",   1'b1, ADD,     32'hFFFFFFFF, 32'h6, 32'h5,   1'b0, 1'b1, 1'b0);
    step("rsv_0011",   1'b1, 4'b0011, 32'hFFFFFFFF, 32'h6, 32'h0,   1'b1, 1'b0, 1'b0);
    step("rsv_1111",   1'b1, 4'b1111, 32'h5, 32'h6,        32'h0,   1'b1, 1'b0, 1'b0);
    step("mid_reset",  1'b0, ADD,     32'h1, 32'h1,        32'h0,   1'b0, 1'b0, 1'b0);
    step("post_reset", 1'b1, ADD,     32'h1, 32'h1,        32'h2,   1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu.md
Name: alu

Overview:
Registered 32-bit integer ALU for the datapath execute stage. Each clock it computes one operation on two operands, selected by a 4-bit opcode. It registers the result and three status flags: zero, carry, overflow. Results appear one clock after the operands are sampled.

Parameters:
WIDTH, 32, operand/result width in bits (must be a power of two, ≥8)
SHAMT_W, 5, shift-amount bits taken from op2 (= log2(WIDTH))

Ports:
clk  input  1  system clock; all state updates on rising edge
rst_n  input  1  synchronous active-low reset, sampled on rising clk edge
op1  input  WIDTH  operand A
op2  input  WIDTH  operand B; for shifts only op2[SHAMT_W-1:0] is used
alu_sel  input  4  operation select
alu_out  output  WIDTH  registered result
zero  output  1  registered; 1 when the result is all zeros
carry  output  1  registered; adder carry-out / subtract borrow
overflow  output  1  registered; signed overflow for ADD/SUB

Behaviour:
- Interface: one clock (clk); reset rst_n is synchronous and active-low.
- Reset: on a rising edge with rst_n=0, alu_out=0, zero=0, carry=0, overflow=0. Reset has priority over any operation. Asserting reset mid-stream discards the in-flight result.
- Latency: operands and alu_sel are sampled on rising edge N. The outputs hold that result from edge N to edge N+1.
- No handshake: an operation is issued every cycle, and outputs always reflect the previous cycle's inputs.
- Opcodes (R = next alu_out):
  - 0000 ADD: R = op1+op2 mod 2^WIDTH. carry = bit WIDTH of the unsigned sum. overflow = operands have the same sign and R's sign differs.
  - 0001 SUB: R = op1-op2 mod 2^WIDTH. carry = 1 iff op1 < op2 unsigned (borrow). overflow = operand signs differ and R's sign differs from op1's.
  - 0100 AND: R = op1 & op2.
  - 0101 OR: R = op1 | op2.
  - 0110 XOR: R = op1 ^ op2.
  - 0111 NOR: R = ~(op1 | op2).
  - 1000 SLL: R = op1 << op2[SHAMT_W-1:0], zero fill.
  - 1001 SRL: R = op1 >> shamt, zero fill.
  - 1010 SRA: R = op1 >> shamt, sign fill from op1[WIDTH-1].
  - 1011 SLT: R = 1 if op1 < op2 signed, else 0.
  - 1100 SLTU: R = 1 if op1 < op2 unsigned, else 0.
  - 1101 EQ: R = 1 if op1 == op2, else 0.
  - 1110 NE: R = 1 if op1 != op2, else 0.
  - 0010, 0011, 1111 reserved: R = 0.
- carry and overflow are 0 for every opcode except ADD and SUB.
- zero = (R == 0) for every opcode, including reserved codes (zero=1 there).
- Shift amount 0 passes op1 unchanged. Bits of op2 above SHAMT_W-1 are ignored for shifts (e.g. op2=0x21 shifts by 1).
- Comparison results are zero-extended to WIDTH.
- Boundaries:
  - ADD 0xFFFFFFFF+1 → R=0, carry=1, overflow=0, zero=1.
  - SUB 0x80000000-1 → R=0x7FFFFFFF, overflow=1, carry=0.
  - SRA of a positive value fills with 0.
- X/unknown alu_sel must not be relied on; any undecoded value falls into the reserved path.
- Purely synthesizable: one combinational datapath feeding one output register bank. No latches.

Test Plan:
- Reset: hold rst_n=0 for 2 edges with op1=0x10, op2=0x20, ADD → all outputs 0. Release; one edge later alu_out=0x30, zero=0, carry=0, overflow=0.
- Arithmetic:
  - ADD 0x7FFFFFFF+0x1 → 0x80000000, overflow=1, carry=0.
  - ADD 0xFFFFFFFF+0x1 → 0x0, carry=1, zero=1.
  - SUB 0x20-0x10 → 0x10, carry=0.
  - SUB 0x10-0x20 → 0xFFFFFFF0, carry=1, overflow=0.
- Logic:
  - AND 0xF0F0F0F0,0x0F0F0F0F → 0x0, zero=1.
  - OR same operands → 0xFFFFFFFF.
  - XOR 0xAAAAAAAA,0x55555555 → 0xFFFFFFFF.
  - NOR 0xF0F0F0F0,0x0F0F0F0F → 0x0.
- Shifts:
  - SLL 0x1 by 2 → 0x4.
  - SRL 0x4 by 1 → 0x2.
  - SRA 0x80000000 by 1 → 0xC0000000.
  - SRL 0x80000000 by 31 → 0x1.
  - SLL 0x1 with op2=0x21 → 0x2.
- Compares:
  - SLTU 0x10,0x20 → 1.
  - SLTU 0xFFFFFFFF,0x1 → 0.
  - SLT 0xFFFFFFFF,0x1 → 1.
  - EQ 0x20,0x20 → 1.
  - NE 0x20,0x20 → 0, zero=1.
- Pipelining/reserved: issue ADD then alu_sel=0011 on back-to-back cycles → ADD result first, then alu_out=0, zero=1, carry=0, overflow=0. Assert rst_n=0 on the edge after the reserved op → outputs 0 next edge.
